// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the fetch stage           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_timer: saturating wait counter for outstanding memory requests |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_max  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The count holds the number of wait cycles already elapsed, so the
    // TIMEOUT-th waiting cycle is the one where it reads TIMEOUT-1.
    assign o_expired = i_enable && (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch: PC-driven fetch with req/ack memory and handshake |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              PCWre,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_err
);

    localparam logic [DATA_W-1:0] c_nop = DATA_W'(NOP_INSN);

    fetch_state_t      r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_inst_out;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic              r_fetch_err;
    logic              r_discard;
    logic              w_expired;
    logic              w_timer_clear;
    logic              w_timer_en;

    assign w_timer_clear = (r_state == IDLE);
    assign w_timer_en    = (r_state == REQ);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (CLK),
        .rst       (Reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst_out   <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_discard    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_addr <= IAddr;
                    r_inst_pc  <= IAddr;
                    if (IAddr[1:0] != 2'b00) begin
                        r_inst_out   <= c_nop;
                        r_fetch_err  <= 1'b1;
                        r_inst_valid <= 1'b1;
                        r_state      <= HOLD;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack || w_expired) begin
                        r_mem_req <= 1'b0;
                        r_discard <= 1'b0;
                        if (r_discard || flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_inst_out   <= mem_ack ? mem_rdata : c_nop;
                            r_fetch_err  <= ~mem_ack;
                            r_inst_valid <= 1'b1;
                            r_state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (flush || inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Combinational so the PC advances on the same edge that leaves HOLD.
    assign PCWre      = (r_state == HOLD) && inst_ready && !flush;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign inst_out   = r_inst_out;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign fetch_err  = r_fetch_err;

endmodule
`default_nettype wire
